fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 3-stage RV32I pipeline, directly upstream of the decode/controller stage.
- Owns the PC and drives BIOS and IMEM synchronous-read ports.
- Selects the returning instruction word and presents inst/inst_pc to decode.
- Applies EX-stage redirects (taken branch, JAL, JALR) with zero added bubbles. Supports decode stall by replaying the current address. Keeps a delivered-instruction counter.

Parameters:
RESET_PC, 32'h4000_0000, first fetch address after reset (BIOS base)
BIOS_AW, 12, BIOS word-address width (addr[13:2])
IMEM_AW, 14, IMEM word-address width (addr[15:2])
NOP, 32'h0000_0013, word driven when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept; hold current instruction
redirect  in  1  EX resolved a taken control transfer this cycle
redirect_target  in  32  new PC (ALU result); bits [1:0] ignored
bios_addr  out  BIOS_AW  BIOS word address (combinational)
bios_en  out  1  BIOS read enable
bios_dout  in  32  BIOS data, 1 cycle after address
imem_addr  out  IMEM_AW  IMEM word address (combinational)
imem_en  out  1  IMEM read enable
imem_dout  in  32  IMEM data, 1 cycle after address
inst  out  32  instruction to decode
inst_pc  out  32  PC of inst
inst_valid  out  1  inst is a real fetched instruction
fetch_fault  out  1  sticky: a request was issued to an unmapped address
fetch_count  out  32  number of instructions accepted by decode

Behaviour:
- State registers:
  - fetch_pc: next sequential request address.
  - req_pc: address issued last cycle.
  - req_src: BIOS / IMEM / NONE, set from the issued address.
  - req_live: a request was issued last cycle.
  - fault, count.
- Issue address (combinational), in priority order: rst -> RESET_PC; redirect -> {redirect_target[31:2],2'b00}; stall -> req_pc (replay the word now in decode); else fetch_pc.
- Region decode of issue address:
  - [31:28]==4'h4 -> BIOS.
  - [31:28]==4'h1 -> IMEM.
  - Else NONE.
  - bios_en/imem_en assert only for their own region and only when not in rst.
  - Addresses are issue_addr[2+AW-1:2].
- fetch_pc next: rst -> RESET_PC; redirect -> target+4; stall -> hold; else fetch_pc+4. Wraps modulo 2^32 with no special handling.
- Each non-rst cycle: req_pc <= issue addr, req_src <= region, req_live <= 1.
- Output (combinational from registered select):
  - inst = req_src BIOS ? bios_dout : IMEM ? imem_dout : NOP.
  - inst_pc = req_pc.
  - inst_valid = req_live && req_src != NONE.
- Latency: request in cycle t produces its instruction in cycle t+1. After a redirect in cycle t, the target instruction is at inst in t+1.
- Redirect does not alter inst in its own cycle. Killing the wrong-path word already in decode is the controller's responsibility.
- redirect together with stall: redirect wins; stall is ignored that cycle.
- fault: set when an issued address decodes to NONE; cleared only by rst.
- count: increments when inst_valid && !stall. A stalled or replayed word is counted once, in the cycle it is accepted.
- Reset values (cycle after rst high): req_pc=0, req_src=NONE, req_live=0, so inst=NOP, inst_valid=0, inst_pc=0. Also fetch_fault=0, fetch_count=0, fetch_pc=RESET_PC.
- First cycle with rst low: issues RESET_PC. The next cycle shows inst_valid=1, inst_pc=RESET_PC.
- rst mid-stall or mid-redirect: rst overrides all; there is no pending state to drain.

Decomposition:
- Shared package (shared with the controller/datapath): NOP word, RESET_PC, BIOS/IMEM region nibbles (4'h4, 4'h1), src encoding (NONE=0, BIOS=1, IMEM=2).
- Sub-module fetch_region_decode: address -> src and enables, combinational. It is reused by the load/store path's memory map.

Test Plan:
- Reset then free-run with a BIOS image -> cycle 1 after rst: inst_pc=0x4000_0000, valid=1; successive cycles: inst_pc +4; fetch_count=3 after 3 accepted words.
- stall high 2 cycles while inst_pc=0x4000_0008 -> inst and inst_pc are unchanged both cycles and bios_addr=2. fetch_count increments once. The cycle after release shows 0x4000_000C.
- redirect=1, target=0x1000_0040 -> same cycle imem_en=1, imem_addr=0x10, bios_en=0. Next cycle inst=imem word 0x10, inst_pc=0x1000_0040. Then 0x1000_0044.
- redirect and stall together with target 0x4000_0100 -> redirect taken; next inst_pc=0x4000_0100.
- redirect to 0x2000_0000 -> both enables 0; next cycle inst=0x0000_0013, inst_valid=0, fetch_fault=1 and it stays 1 until rst.
- redirect target 0x1000_0043 -> issued as 0x1000_0040 (low bits ignored).

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and source encoding shared by fetch, controller and datapath
package fetch_unit_pkg;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [3:0] BIOS_NIB = 4'h4;
  localparam logic [3:0] IMEM_NIB = 4'h1;
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BIOS = 2'd1,
    SRC_IMEM = 2'd2
  } src_e;
endpackage

// File: rtl/fetch_unit_region_decode.sv
// fetch_unit_region_decode: maps a byte address to its memory region and per-region selects
module fetch_unit_region_decode
  import fetch_unit_pkg::*;
(
  input  logic [31:0] i_addr,
  output src_e        o_src,
  output logic        o_bios_sel,
  output logic        o_imem_sel
);
  assign o_bios_sel = i_addr[31:28] == BIOS_NIB;
  assign o_imem_sel = i_addr[31:28] == IMEM_NIB;
  assign o_src = o_bios_sel ? SRC_BIOS : o_imem_sel ? SRC_IMEM : SRC_NONE;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues BIOS/IMEM reads and presents the returning word to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14,
  parameter logic [31:0] NOP = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic               bios_en,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic               inst_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);
  logic [31:0] r_fetch_pc, r_req_pc, r_count;
  src_e        r_req_src;
  logic        r_req_live, r_fault;
  logic [31:0] w_target, w_issue;
  src_e        w_src;
  logic        w_bios_sel, w_imem_sel;
  assign w_target = {redirect_target[31:2], 2'b00};
  // Stall replays the word currently in decode; redirect overrides stall
  assign w_issue = rst ? RESET_PC : redirect ? w_target : stall ? r_req_pc : r_fetch_pc;
  fetch_unit_region_decode u_dec (
    .i_addr    (w_issue),
    .o_src     (w_src),
    .o_bios_sel(w_bios_sel),
    .o_imem_sel(w_imem_sel)
  );
  assign bios_en   = w_bios_sel && !rst;
  assign imem_en   = w_imem_sel && !rst;
  assign bios_addr = w_issue[2+BIOS_AW-1:2];
  assign imem_addr = w_issue[2+IMEM_AW-1:2];
  assign inst_valid  = r_req_live && r_req_src != SRC_NONE;
  assign inst_pc     = r_req_pc;
  assign inst        = r_req_src == SRC_BIOS ? bios_dout : r_req_src == SRC_IMEM ? imem_dout : NOP;
  assign fetch_fault = r_fault;
  assign fetch_count = r_count;
  // PC sequencing, request tracking, sticky fault and accepted-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_req_src  <= SRC_NONE;
      r_req_live <= 1'b0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= redirect ? w_target + 32'd4 : stall ? r_fetch_pc : r_fetch_pc + 32'd4;
      r_req_pc   <= w_issue;
      r_req_src  <= w_src;
      r_req_live <= 1'b1;
      r_fault    <= r_fault || w_src == SRC_NONE;
      r_count    <= r_count + 32'(inst_valid && !stall);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_target;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic        bios_en, imem_en, inst_valid, fetch_fault;
  logic [31:0] bios_dout, imem_dout, inst, inst_pc, fetch_count;
  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];
  int errors = 0, checks = 0;
  logic [31:0] m_pc, m_req_pc, m_count;
  logic        m_live, m_fault;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .bios_addr(bios_addr), .bios_en(bios_en), .bios_dout(bios_dout),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bios_en) bios_dout <= bios_mem[bios_addr];
    if (imem_en) imem_dout <= imem_mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    return a[31:28] == 4'h4 ? 1 : a[31:28] == 4'h1 ? 2 : 0;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int r = region(a);
    return r == 1 ? bios_mem[a[13:2]] : r == 2 ? imem_mem[a[15:2]] : 32'h0000_0013;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
    logic [31:0] issue;
    int reg_i;
    rst = r; stall = s; redirect = rd; redirect_target = t;
    #1;
    issue = r ? 32'h4000_0000 : rd ? {t[31:2], 2'b00} : s ? m_req_pc : m_pc;
    reg_i = region(issue);
    check("bios_en", 32'(bios_en), 32'(!r && reg_i == 1));
    check("imem_en", 32'(imem_en), 32'(!r && reg_i == 2));
    if (reg_i == 1) check("bios_addr", 32'(bios_addr), 32'(issue[13:2]));
    if (reg_i == 2) check("imem_addr", 32'(imem_addr), 32'(issue[15:2]));
    @(posedge clk);
    if (r) begin
      m_pc = 32'h4000_0000; m_req_pc = 0; m_live = 0; m_fault = 0; m_count = 0;
    end else begin
      if (m_live && region(m_req_pc) != 0 && !s) m_count++;
      m_pc = rd ? {t[31:2], 2'b00} + 4 : s ? m_pc : m_pc + 4;
      m_req_pc = issue;
      m_live = 1;
      if (reg_i == 0) m_fault = 1;
    end
    #1;
    check("inst_pc", inst_pc, m_req_pc);
    check("inst_valid", 32'(inst_valid), 32'(m_live && region(m_req_pc) != 0));
    check("inst", inst, m_live ? word_at(m_req_pc) : 32'h0000_0013);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check("fetch_count", fetch_count, m_count);
  endtask

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 4096; i++) bios_mem[i] = $urandom;
    for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom;
    m_pc = 0; m_req_pc = 0; m_live = 0; m_fault = 0; m_count = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_pc", inst_pc, 0);
    cyc(0, 0, 0, 0);
    check("first_pc", inst_pc, 32'h4000_0000);
    check("first_valid", 32'(inst_valid), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("pc_08", inst_pc, 32'h4000_0008);
    cyc(0, 1, 0, 0);
    check("stall_bios_addr", 32'(bios_addr), 2);
    cyc(0, 1, 0, 0);
    check("stall_pc", inst_pc, 32'h4000_0008);
    check("stall_inst", inst, bios_mem[2]);
    cyc(0, 0, 0, 0);
    check("after_stall_pc", inst_pc, 32'h4000_000C);
    check("count3", fetch_count, 3);
    cyc(0, 0, 1, 32'h1000_0040);
    check("redir_inst", inst, imem_mem[16]);
    check("redir_pc", inst_pc, 32'h1000_0040);
    cyc(0, 0, 0, 0);
    check("redir_next_pc", inst_pc, 32'h1000_0044);
    cyc(0, 1, 1, 32'h4000_0100);
    check("redir_stall_pc", inst_pc, 32'h4000_0100);
    cyc(0, 0, 1, 32'h1000_0043);
    check("low_bits_pc", inst_pc, 32'h1000_0040);
    cyc(0, 0, 1, 32'h2000_0000);
    check("unmapped_inst", inst, 32'h0000_0013);
    check("unmapped_valid", 32'(inst_valid), 0);
    check("fault_set", 32'(fetch_fault), 1);
    cyc(0, 0, 1, 32'h4000_0010);
    cyc(0, 0, 0, 0);
    check("fault_sticky", 32'(fetch_fault), 1);
    cyc(1, 1, 1, 32'h1000_0000);
    check("fault_cleared", 32'(fetch_fault), 0);
    cyc(0, 0, 1, 32'h4000_3FF8);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: t = 32'h4000_0000 | 32'($urandom_range(0, 16'h3FFF));
        1: t = 32'h1000_0000 | 32'($urandom_range(0, 32'hFFFF));
        2: t = ($urandom_range(0, 9) == 0) ? $urandom : 32'h4000_3FF0 | 32'($urandom_range(0, 15));
        default: t = 32'h1000_FFF0 | 32'($urandom_range(0, 15));
      endcase
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
